// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request
// in flight at most, and hands fetched words to decode through a one-entry IF/ID register.
module inst_fetch_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            id_ready_i,
  output logic            id_valid_o,
  output logic [31:0]     id_inst_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_plus4_o
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;

  logic            buf_free_s;
  logic            req_s;
  logic            handshake_s;
  logic            load_s;

  // A request only issues once the IF/ID entry is guaranteed free, so a response never stalls.
  assign buf_free_s  = !id_valid_q || id_ready_i;
  assign req_s       = rst_n && (state_q == ST_REQ) && buf_free_s;
  assign handshake_s = req_s && imem_ready_i;
  assign load_s      = (state_q == ST_WAIT) && imem_rvalid_i && !drop_q && !redirect_i;

  assign imem_req_o    = req_s;
  assign imem_addr_o   = pc_q;
  assign id_valid_o    = id_valid_q;
  assign id_inst_o     = id_inst_q;
  assign id_pc_o       = id_pc_q;
  assign id_pc_plus4_o = id_pc_plus4_q;

  // Next-state logic for the request FSM, PC and IF/ID register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    drop_d        = drop_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;

    if (id_valid_q && id_ready_i) begin
      id_valid_d = 1'b0;
    end else begin
      id_valid_d = id_valid_q;
    end

    case (state_q)
      ST_REQ: begin
        if (handshake_s) begin
          state_d  = ST_WAIT;
          req_pc_d = pc_q;
        end else begin
          state_d  = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    endcase

    if (load_s) begin
      id_valid_d    = 1'b1;
      id_inst_d     = imem_rdata_i;
      id_pc_d       = req_pc_q;
      id_pc_plus4_d = req_pc_q + XLEN'(4);
      pc_d          = req_pc_q + XLEN'(4);
    end else begin
      id_inst_d     = id_inst_d;
    end

    // Redirect wins: any request already accepted for the old PC must be dropped on return.
    if (redirect_i) begin
      pc_d       = {redirect_target_i[XLEN-1:2], 2'b00};
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      drop_d     = (state_q == ST_WAIT) ? !imem_rvalid_i : handshake_s;
    end else begin
      pc_d       = pc_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      drop_q        <= 1'b0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      drop_q        <= drop_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed vector table, reset-in-flight sequence,
// then random traffic checked against a program-order fetch model.
module tb_inst_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] FC  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid, redirect, id_ready, id_valid;
  logic [63:0] imem_addr, redirect_target, id_pc, id_pc_plus4;
  logic [31:0] imem_rdata, id_inst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_stage #(.XLEN(64), .RESET_PC(64'h1000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_target_i(redirect_target),
    .id_ready_i(id_ready), .id_valid_o(id_valid), .id_inst_o(id_inst),
    .id_pc_o(id_pc), .id_pc_plus4_o(id_pc_plus4)
  );

  typedef struct {
    logic        rdy, rv, idr, red;
    logic [31:0] rdata;
    logic [63:0] tgt;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [63:0] e_pc, e_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], 16'h0000} ^ 32'h1357_9BDF;
  endfunction

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata, input logic idr,
                     input logic red, input logic [63:0] tgt, input logic e_req,
                     input logic [63:0] e_addr, input logic e_valid, input logic [31:0] e_inst,
                     input logic [63:0] e_pc, input logic [63:0] e_pc4);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr; v.red = red; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_inst = e_inst;
    v.e_pc = e_pc; v.e_pc4 = e_pc4;
    vecs.push_back(v);
  endtask

  // random-phase model state
  logic [63:0] exp_pc, o_addr, h_pc;
  logic [31:0] h_inst;
  logic        out, flush_pend, hold_pend, hs;
  int          cnt, accepted;

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_target = 64'h0; id_ready = 1'b0;

    // directed table: per cycle inputs, pre-edge request, post-edge IF/ID contents
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b0, NOP, 64'h0, 64'h0);
    add(1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 64'h0, 1'b0, 64'h1000, 1'b1, 32'h0050_0093, 64'h1000, 64'h1004);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h1004, 1'b0, 32'h0050_0093, 64'h1000, 64'h1004);
    add(1'b0, 1'b1, 32'h0010_0113, 1'b1, 1'b0, 64'h0, 1'b0, 64'h1004, 1'b1, 32'h0010_0113, 64'h1004, 64'h1008);
    for (int i = 0; i < 5; i++)
      add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h1008, 1'b1, 32'h0010_0113, 64'h1004, 64'h1008);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h1008, 1'b0, 32'h0010_0113, 64'h1004, 64'h1008);
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h2002, 1'b0, 64'h1008, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h2000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h2000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'h0, 1'b0, 64'h2000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h2000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b1, 32'h0000_0093, 1'b1, 1'b1, 64'h3000, 1'b0, 64'h2000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h4000, 1'b1, 64'h3000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h4000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 64'h0, 1'b0, 64'h4000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h4000, 1'b0, NOP, 64'h1004, 64'h1008);
    add(1'b0, 1'b1, 32'h00A0_0513, 1'b1, 1'b0, 64'h0, 1'b0, 64'h4000, 1'b1, 32'h00A0_0513, 64'h4000, 64'h4004);
    add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h4004, 1'b0, NOP, 64'h4000, 64'h4004);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, FC, 1'b0, NOP, 64'h4000, 64'h4004);
    add(1'b0, 1'b1, 32'h00C0_0593, 1'b1, 1'b0, 64'h0, 1'b0, FC, 1'b1, 32'h00C0_0593, FC, 64'h0);
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 1'b0, 32'h00C0_0593, FC, 64'h0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", imem_addr, 64'h1000);
    chk("rst_valid", {63'h0, id_valid}, 64'h0);
    chk("rst_inst", {32'h0, id_inst}, {32'h0, NOP});
    chk("rst_pc", id_pc, 64'h0);
    chk("rst_pc4", id_pc_plus4, 64'h0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      imem_ready = vecs[k].rdy; imem_rvalid = vecs[k].rv; imem_rdata = vecs[k].rdata;
      id_ready = vecs[k].idr; redirect = vecs[k].red; redirect_target = vecs[k].tgt;
      #4;
      chk($sformatf("v%0d_req", k), {63'h0, imem_req}, {63'h0, vecs[k].e_req});
      chk($sformatf("v%0d_addr", k), imem_addr, vecs[k].e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", k), {63'h0, id_valid}, {63'h0, vecs[k].e_valid});
      chk($sformatf("v%0d_inst", k), {32'h0, id_inst}, {32'h0, vecs[k].e_inst});
      chk($sformatf("v%0d_pc", k), id_pc, vecs[k].e_pc);
      chk($sformatf("v%0d_pc4", k), id_pc_plus4, vecs[k].e_pc4);
    end

    // reset pulse while a request is outstanding
    imem_ready = 1'b1; imem_rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {63'h0, imem_req}, 64'h0);
    chk("arst_addr", imem_addr, 64'h1000);
    chk("arst_valid", {63'h0, id_valid}, 64'h0);
    chk("arst_inst", {32'h0, id_inst}, {32'h0, NOP});
    chk("arst_pc", id_pc, 64'h0);
    chk("arst_pc4", id_pc_plus4, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ready = 1'b1;
    #3;
    chk("restart_req", {63'h0, imem_req}, 64'h1);
    chk("restart_addr", imem_addr, 64'h1000);
    @(posedge clk); #1;
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(64'h1000); id_ready = 1'b0;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    chk("restart_valid", {63'h0, id_valid}, 64'h1);
    chk("restart_pc", id_pc, 64'h1000);
    chk("restart_inst", {32'h0, id_inst}, {32'h0, word(64'h1000)});

    // random traffic against a program-order model
    exp_pc = 64'h1000; out = 1'b0; cnt = 0; o_addr = 64'h0;
    flush_pend = 1'b0; hold_pend = 1'b0; h_pc = 64'h0; h_inst = 32'h0; accepted = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_rvalid     = out && (cnt == 0);
      imem_rdata      = imem_rvalid ? word(o_addr) : 32'($urandom);
      imem_ready      = ($urandom % 4) != 0;
      id_ready        = ($urandom % 3) != 0;
      redirect        = ($urandom % 12) == 0;
      redirect_target = {32'($urandom), 32'($urandom)};
      #4;
      chk("addr_align", {62'h0, imem_addr[1:0]}, 64'h0);
      if (flush_pend) chk("flush_valid", {63'h0, id_valid}, 64'h0);
      if (hold_pend) begin
        chk("hold_inst", {32'h0, id_inst}, {32'h0, h_inst});
        chk("hold_pc", id_pc, h_pc);
      end
      if (id_valid && !id_ready) chk("req_blocked", {63'h0, imem_req}, 64'h0);
      hs = imem_req && imem_ready;
      chk("one_outstanding", {63'h0, hs && out && !imem_rvalid}, 64'h0);
      if (redirect) begin
        exp_pc = {redirect_target[63:2], 2'b00};
      end else if (id_valid && id_ready) begin
        chk("rand_pc", id_pc, exp_pc);
        chk("rand_inst", {32'h0, id_inst}, {32'h0, word(exp_pc)});
        chk("rand_pc4", id_pc_plus4, exp_pc + 64'd4);
        exp_pc = exp_pc + 64'd4;
        accepted++;
      end
      flush_pend = redirect;
      hold_pend  = id_valid && !id_ready && !redirect;
      h_inst = id_inst; h_pc = id_pc;
      if (imem_rvalid) out = 1'b0;
      else if (out) cnt--;
      if (hs) begin
        out = 1'b1; o_addr = imem_addr; cnt = $urandom_range(0, 2);
      end
      @(posedge clk); #1;
    end
    chk("liveness", {63'h0, accepted >= 200}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decoder and signal controller. It owns the PC, issues one instruction-memory request at a time, and presents the fetched word to decode as a single-entry IF/ID register with a valid/ready handshake. It redirects the PC when the controller's pc_src asserts, and squashes any in-flight or buffered wrong-path instruction.

Parameters:
XLEN, 64, width of PC and addresses (RV64).
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INST, 32'h00000013, value of id_inst after reset or flush (addi x0,x0,0).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req  out  1  request valid to instruction memory.
imem_addr  out  XLEN  request address, always equal to the pc register.
imem_ready  in  1  memory accepts the request this cycle (imem_req & imem_ready = handshake).
imem_rvalid  in  1  response valid; arrives 1 or more cycles after the handshake.
imem_rdata  in  32  instruction word.
redirect  in  1  take redirect_target (pc_src from the signal controller).
redirect_target  in  XLEN  branch or jump target; bits [1:0] are forced to 0 on load.
id_ready  in  1  decode accepts id_* this cycle.
id_valid  out  1  IF/ID register holds a valid instruction.
id_inst  out  32  instruction to decoder (opcode = id_inst[6:0]).
id_pc  out  XLEN  PC of id_inst.
id_pc_plus4  out  XLEN  id_pc + 4, registered (return address for jal/jalr).

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=REQ, drop=0, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_plus4=0. imem_req=0 while rst_n is low.
- FSM states are REQ and WAIT. At most one request is outstanding.
- buf_free = !id_valid | id_ready.
- REQ: imem_req = buf_free. On handshake, go to WAIT and latch req_pc=pc.
- WAIT: imem_req=0. On imem_rvalid with drop=0: id_inst=imem_rdata, id_pc=req_pc, id_pc_plus4=req_pc+4, id_valid=1, pc=req_pc+4, go to REQ. On imem_rvalid with drop=1: discard the response, clear drop, go to REQ, leave pc unchanged.
- Requests issue only when buf_free, so the IF/ID register is always empty when a response arrives. Responses are never stalled.
- id_valid clears when id_valid & id_ready, unless a response loads it in the same cycle.
- Best-case throughput is one instruction every 2 cycles with 1-cycle memory latency. id_* is registered, so decode sees the word one cycle after imem_rvalid.
- PC arithmetic wraps modulo 2^XLEN, e.g. 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Redirect has priority over every other event in the same cycle:
  - pc = {redirect_target[XLEN-1:2],2'b00}.
  - Flush: id_valid=0, id_inst=NOP_INST.
  - WAIT, no rvalid: set drop=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: discard the response, go to REQ, drop=0.
  - REQ with handshake in the same cycle: the old-pc request is in flight, so set drop=1 and go to WAIT.
  - REQ, no handshake: stay in REQ. imem_addr changes to the target next cycle; an unaccepted request may change address.
- A second redirect while drop=1 only updates pc; drop stays 1 (a single stale response is still pending).
- Reset asserted mid-transaction returns everything to reset values immediately. Memory must also be reset, so no stale rvalid follows.
- imem_addr[1:0] is always 2'b00.

Test Plan:
- Reset release, RESET_PC=0x1000, 1-cycle memory returning 0x00500093, 0x00100113, id_ready=1 -> imem_addr 0x1000 then 0x1004; id_pc=0x1000/id_inst=0x00500093 then id_pc=0x1004; id_pc_plus4=0x1004/0x1008.
- Hold id_ready=0 for 5 cycles with id_valid=1 -> imem_req stays 0, id_* stable. On id_ready=1, the request for the next PC issues in that same cycle.
- Redirect to 0x2002 while in WAIT; the stale response arrives 3 cycles later -> stale word never appears on id_valid; next imem_addr=0x2000; id_valid=0 during the flush.
- Redirect in the same cycle as imem_rvalid (target 0x3000) -> response discarded, next cycle imem_req=1, imem_addr=0x3000.
- Redirect in the same cycle as the REQ handshake, memory latency 2 -> drop=1; the first response is discarded; the following request is at the target address.
- rst_n pulsed low for one cycle during WAIT -> outputs return to reset values asynchronously; fetch restarts at RESET_PC with id_inst=0x00000013.
